// File: rtl/legv8_mc_control.sv
// Multicycle LEGv8 control FSM: sequences fetch/decode/execute/memory/write-back
// and drives datapath selects and strobes, stalling on the memory ready handshake.
module legv8_mc_control #(
  parameter int OPC_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPC_WIDTH-1:0] opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 branch_ne,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg2loc,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 pc_source,
  output logic                 retire,
  output logic                 illegal,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_CBR      = 4'd10,
    S_BR       = 4'd11,
    S_HALT     = 4'd15
  } state_t;

  state_t r_state, w_next;
  logic   r_illegal;
  logic   w_is_r, w_is_i, w_is_ld, w_is_st, w_is_cb, w_is_b, w_is_ill;

  // The branch condition itself is resolved in the datapath from zero/branch_ne.
  logic w_zero_unused;
  assign w_zero_unused = zero;

  always_comb begin
    w_is_r  = 1'b0;
    w_is_i  = 1'b0;
    w_is_ld = 1'b0;
    w_is_st = 1'b0;
    w_is_cb = 1'b0;
    w_is_b  = 1'b0;
    if (opcode == 11'b10001011000 || opcode == 11'b11001011000 ||
        opcode == 11'b10001010000 || opcode == 11'b10101010000)
      w_is_r = 1'b1;
    else if (opcode[10:1] == 10'b1001000100 || opcode[10:1] == 10'b1101000100)
      w_is_i = 1'b1;
    else if (opcode == 11'b11111000010)
      w_is_ld = 1'b1;
    else if (opcode == 11'b11111000000)
      w_is_st = 1'b1;
    else if (opcode[10:4] == 7'b1011010)
      w_is_cb = 1'b1;
    else if (opcode[10:5] == 6'b000101)
      w_is_b = 1'b1;
  end

  assign w_is_ill = ~(w_is_r | w_is_i | w_is_ld | w_is_st | w_is_cb | w_is_b);
  assign reg2loc  = w_is_st | w_is_cb;
  assign illegal  = r_illegal;
  assign state    = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && w_is_ill) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 1'b0;
    retire        = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed here speculatively into ALUOut.
        alu_src_b = 2'b11;
        if (w_is_r)                 w_next = S_EXEC_R;
        else if (w_is_i)            w_next = S_EXEC_I;
        else if (w_is_ld | w_is_st) w_next = S_MEM_ADDR;
        else if (w_is_cb)           w_next = S_CBR;
        else if (w_is_b)            w_next = S_BR;
        else                        w_next = S_HALT;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b11;
        alu_op    = 2'b10;
        w_next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b11;
        w_next    = w_is_ld ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_CBR: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        branch_ne     = opcode[3];
        retire        = 1'b1;
        w_next        = S_FETCH;
      end
      S_BR: begin
        pc_write  = 1'b1;
        pc_source = 1'b1;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_legv8_mc_control.sv
// Bench for legv8_mc_control: directed vector table, reset/illegal sequences,
// then random instruction streams checked against a phase-list model.
module tb_legv8_mc_control;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aop;
    logic [1:0] bsel;
    logic asel, mrd, mwr, iord, irw, pcw, pcc, bne, psrc, rw, m2r, ret, r2l, ill;
  } out_t;

  typedef struct {
    logic [10:0] opc;
    logic        rdy;
    logic        z;
    out_t        exp;
  } vec_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBNZ = 11'b10110101000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100111;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_ADDI = 11'b10010001001;
  localparam logic [10:0] OP_ILL  = 11'b00000000000;

  logic clk = 1'b0, rst = 1'b1;
  logic [10:0] opcode = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic reg2loc, reg_write, mem_to_reg, alu_src_a, pc_source, retire, illegal;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;
  vec_t vq[$];

  legv8_mc_control #(.OPC_WIDTH(11)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg2loc(reg2loc), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .retire(retire), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  function automatic out_t cur();
    return {state, alu_op, alu_src_b, alu_src_a, mem_read, mem_write, iord, ir_write,
            pc_write, pc_write_cond, branch_ne, pc_source, reg_write, mem_to_reg,
            retire, reg2loc, illegal};
  endfunction

  task automatic cmp_out(input string nm, input out_t exp);
    out_t a;
    a = cur();
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, exp);
    end
  endtask

  task automatic step(input string nm, input logic [10:0] opc, input logic rdy,
                      input logic z, input out_t exp);
    opcode = opc; mem_ready = rdy; zero = z;
    #1;
    cmp_out(nm, exp);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic [10:0] opc, input logic rdy, input logic z, input out_t e);
    vq.push_back('{opc, rdy, z, e});
  endtask

  // Random instruction of a given class: 0=R 1=I 2=LDUR 3=STUR 4=CB 5=B.
  function automatic logic [10:0] make_op(input int cls);
    logic [10:0] r;
    logic [10:0] rop[4];
    r = 11'($urandom);
    rop[0] = 11'b10001011000; rop[1] = 11'b11001011000;
    rop[2] = 11'b10001010000; rop[3] = 11'b10101010000;
    case (cls)
      0: return rop[$urandom_range(0, 3)];
      1: return {($urandom_range(0, 1) != 0) ? 10'b1101000100 : 10'b1001000100, r[0]};
      2: return OP_LDUR;
      3: return OP_STUR;
      4: return {7'b1011010, r[3:0]};
      default: return {6'b000101, r[4:0]};
    endcase
  endfunction

  initial begin
    // ---- directed vector table (zero-wait unless noted) ----
    add(OP_ADD, 1, 0, '{st:4'd0, default:0});
    // ADD
    add(OP_ADD, 1, 0, '{st:4'd1, mrd:1'b1, bsel:2'b01, irw:1'b1, pcw:1'b1, default:0});
    add(OP_ADD, 1, 0, '{st:4'd2, bsel:2'b11, default:0});
    add(OP_ADD, 1, 0, '{st:4'd3, asel:1'b1, aop:2'b10, default:0});
    add(OP_ADD, 1, 0, '{st:4'd5, rw:1'b1, ret:1'b1, default:0});
    // LDUR, two wait cycles in MEM_RD
    add(OP_LDUR, 1, 0, '{st:4'd1, mrd:1'b1, bsel:2'b01, irw:1'b1, pcw:1'b1, default:0});
    add(OP_LDUR, 1, 0, '{st:4'd2, bsel:2'b11, default:0});
    add(OP_LDUR, 1, 0, '{st:4'd6, asel:1'b1, bsel:2'b11, default:0});
    add(OP_LDUR, 0, 0, '{st:4'd7, mrd:1'b1, iord:1'b1, default:0});
    add(OP_LDUR, 0, 0, '{st:4'd7, mrd:1'b1, iord:1'b1, default:0});
    add(OP_LDUR, 1, 0, '{st:4'd7, mrd:1'b1, iord:1'b1, default:0});
    add(OP_LDUR, 1, 0, '{st:4'd8, rw:1'b1, m2r:1'b1, ret:1'b1, default:0});
    // STUR, one wait cycle in MEM_WR
    add(OP_STUR, 1, 0, '{st:4'd1, mrd:1'b1, bsel:2'b01, irw:1'b1, pcw:1'b1, r2l:1'b1, default:0});
    add(OP_STUR, 1, 0, '{st:4'd2, bsel:2'b11, r2l:1'b1, default:0});
    add(OP_STUR, 1, 0, '{st:4'd6, asel:1'b1, bsel:2'b11, r2l:1'b1, default:0});
    add(OP_STUR, 0, 0, '{st:4'd9, mwr:1'b1, iord:1'b1, r2l:1'b1, default:0});
    add(OP_STUR, 1, 0, '{st:4'd9, mwr:1'b1, iord:1'b1, ret:1'b1, r2l:1'b1, default:0});
    // CBNZ, zero=0
    add(OP_CBNZ, 1, 0, '{st:4'd1, mrd:1'b1, bsel:2'b01, irw:1'b1, pcw:1'b1, r2l:1'b1, default:0});
    add(OP_CBNZ, 1, 0, '{st:4'd2, bsel:2'b11, r2l:1'b1, default:0});
    add(OP_CBNZ, 1, 0, '{st:4'd10, asel:1'b1, aop:2'b01, pcc:1'b1, bne:1'b1, psrc:1'b1,
                         ret:1'b1, r2l:1'b1, default:0});
    // CBZ, zero=1
    add(OP_CBZ, 1, 1, '{st:4'd1, mrd:1'b1, bsel:2'b01, irw:1'b1, pcw:1'b1, r2l:1'b1, default:0});
    add(OP_CBZ, 1, 1, '{st:4'd2, bsel:2'b11, r2l:1'b1, default:0});
    add(OP_CBZ, 1, 1, '{st:4'd10, asel:1'b1, aop:2'b01, pcc:1'b1, psrc:1'b1,
                        ret:1'b1, r2l:1'b1, default:0});
    // B
    add(OP_B, 1, 0, '{st:4'd1, mrd:1'b1, bsel:2'b01, irw:1'b1, pcw:1'b1, default:0});
    add(OP_B, 1, 0, '{st:4'd2, bsel:2'b11, default:0});
    add(OP_B, 1, 0, '{st:4'd11, pcw:1'b1, psrc:1'b1, ret:1'b1, default:0});
    // ADDI with one fetch wait
    add(OP_ADDI, 0, 0, '{st:4'd1, mrd:1'b1, bsel:2'b01, default:0});
    add(OP_ADDI, 1, 0, '{st:4'd1, mrd:1'b1, bsel:2'b01, irw:1'b1, pcw:1'b1, default:0});
    add(OP_ADDI, 1, 0, '{st:4'd2, bsel:2'b11, default:0});
    add(OP_ADDI, 1, 0, '{st:4'd4, asel:1'b1, bsel:2'b11, aop:2'b10, default:0});
    add(OP_ADDI, 1, 0, '{st:4'd5, rw:1'b1, ret:1'b1, default:0});

    step("reset_state", OP_ADD, 1, 0, '{default:0});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      step($sformatf("vec%0d", i), vq[i].opc, vq[i].rdy, vq[i].z, vq[i].exp);
      @(negedge clk);
    end

    // ---- reset during MEM_RD wait ----
    step("rst_fetch", OP_LDUR, 1, 0, '{st:4'd1, mrd:1'b1, bsel:2'b01, irw:1'b1, pcw:1'b1, default:0});
    @(negedge clk);
    step("rst_decode", OP_LDUR, 1, 0, '{st:4'd2, bsel:2'b11, default:0});
    @(negedge clk);
    step("rst_addr", OP_LDUR, 1, 0, '{st:4'd6, asel:1'b1, bsel:2'b11, default:0});
    @(negedge clk);
    step("rst_memrd", OP_LDUR, 0, 0, '{st:4'd7, mrd:1'b1, iord:1'b1, default:0});
    rst = 1'b1;
    #1 cmp_out("rst_async", '{default:0});
    @(negedge clk);
    step("rst_held", OP_LDUR, 1, 0, '{default:0});
    rst = 1'b0;
    step("rst_idle", OP_LDUR, 0, 0, '{default:0});
    @(negedge clk);
    step("rst_then_fetch", OP_ILL, 0, 0, '{st:4'd1, mrd:1'b1, bsel:2'b01, default:0});
    @(negedge clk);

    // ---- illegal opcode ----
    step("ill_fetch", OP_ILL, 1, 0, '{st:4'd1, mrd:1'b1, bsel:2'b01, irw:1'b1, pcw:1'b1, default:0});
    @(negedge clk);
    step("ill_decode", OP_ILL, 1, 0, '{st:4'd2, bsel:2'b11, default:0});
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      step("ill_halt", OP_ILL, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           '{st:4'd15, ill:1'b1, default:0});
      @(negedge clk);
    end
    rst = 1'b1;
    #1 chk("ill_clear", int'(illegal), 0);
    @(negedge clk);
    rst = 1'b0;
    step("ill_idle", OP_ILL, 1, 0, '{default:0});
    @(negedge clk);

    // ---- random instruction stream vs phase-list model ----
    for (int n = 0; n < 250; n++) begin
      int cls;
      int ph[$];
      logic [10:0] opc;
      cls = $urandom_range(0, 5);
      opc = make_op(cls);
      case (cls)
        0: ph = '{1, 2, 3, 5};
        1: ph = '{1, 2, 4, 5};
        2: ph = '{1, 2, 6, 7, 8};
        3: ph = '{1, 2, 6, 9};
        4: ph = '{1, 2, 10};
        default: ph = '{1, 2, 11};
      endcase
      for (int k = 0; k < ph.size(); ) begin
        logic rdy;
        int s;
        bit memph;
        rdy = ($urandom_range(0, 3) != 0);
        opcode = opc; mem_ready = rdy; zero = 1'($urandom_range(0, 1));
        #1;
        s = ph[k];
        memph = (s == 1 || s == 7 || s == 9);
        chk("rnd_state", int'(state), s);
        chk("rnd_mem_read", int'(mem_read), int'(s == 1 || s == 7));
        chk("rnd_mem_write", int'(mem_write), int'(s == 9));
        chk("rnd_iord", int'(iord), int'(s == 7 || s == 9));
        chk("rnd_ir_write", int'(ir_write), int'(s == 1 && rdy));
        chk("rnd_reg_write", int'(reg_write), int'(s == 5 || s == 8));
        chk("rnd_retire", int'(retire),
            int'(s == 5 || s == 8 || s == 10 || s == 11 || (s == 9 && rdy)));
        chk("rnd_pc_write_cond", int'(pc_write_cond), int'(s == 10));
        chk("rnd_branch_ne", int'(branch_ne), int'(s == 10 && opc[3]));
        chk("rnd_reg2loc", int'(reg2loc), int'(cls == 3 || cls == 4));
        if (!(memph && !rdy)) k++;
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
